// File: rtl/svm_sched_pkg.sv
// Shared types for the SVM batch scheduler: transaction ID width, dependency
// bitmap type and the queued transaction record.
package svm_sched_pkg;

  localparam int ID_W  = 64;
  localparam int DEP_W = 1024;

  typedef logic [DEP_W-1:0] dep_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    dep_t            rd;
    dep_t            wr;
  } txn_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO of scheduler transactions; head is readable combinationally.
// Push is ignored when full and pop is ignored when empty; simultaneous push/pop keeps the count.
module sched_fifo
  import svm_sched_pkg::*;
#(
  parameter type T     = txn_t,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/svm_scheduler_top.sv
// Batch scheduler: drops transactions conflicting with the open batch, queues the rest and
// releases a batch on size or timeout. Accept is same-edge; tready drops in the close cycle or when full.
module svm_scheduler_top
  import svm_sched_pkg::*;
#(
  parameter int MAX_DEPENDENCIES         = DEP_W,
  parameter int MAX_BATCH_SIZE           = 8,
  parameter int BATCH_TIMEOUT_CYCLES     = 100,
  parameter int MAX_PENDING_TRANSACTIONS = 16,
  parameter int INSERTION_QUEUE_DEPTH    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [ID_W-1:0]             s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [ID_W-1:0]             m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  output logic [31:0]                 raw_conflicts,
  output logic [31:0]                 waw_conflicts,
  output logic [31:0]                 war_conflicts,
  output logic [31:0]                 filter_hits,
  output logic [31:0]                 queue_occupancy,
  output logic [31:0]                 transactions_processed
);

  localparam int PEND_CAP = (MAX_PENDING_TRANSACTIONS < INSERTION_QUEUE_DEPTH) ?
                            MAX_PENDING_TRANSACTIONS : INSERTION_QUEUE_DEPTH;
  localparam int BCW = $clog2(MAX_BATCH_SIZE + 1);
  localparam int QCW = $clog2(INSERTION_QUEUE_DEPTH + 1);

  logic [MAX_DEPENDENCIES-1:0] batch_rd_mask;
  logic [MAX_DEPENDENCIES-1:0] batch_wr_mask;
  logic [BCW-1:0]              batch_count;
  logic [31:0]                 batch_timer;
  logic [31:0]                 release_count;

  txn_t           push_data;
  txn_t           head;
  logic [QCW-1:0] fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  logic raw_hit, waw_hit, war_hit, conflict;
  logic close_now, in_hs, accept, out_hs;

  assign raw_hit  = |(s_axis_tdata_read_dependencies  & batch_wr_mask);
  assign waw_hit  = |(s_axis_tdata_write_dependencies & batch_wr_mask);
  assign war_hit  = |(s_axis_tdata_write_dependencies & batch_rd_mask);
  assign conflict = raw_hit || waw_hit || war_hit;

  assign close_now = (batch_count == BCW'(MAX_BATCH_SIZE)) ||
                     ((batch_count != '0) && (batch_timer == 32'(BATCH_TIMEOUT_CYCLES - 1)));

  // Held low while reset is asserted so upstream never sees a ready during reset.
  assign s_axis_tready = rst_n && !close_now && !fifo_full && (fifo_count < QCW'(PEND_CAP));
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign accept        = in_hs && !conflict;

  assign m_axis_tvalid = (release_count != '0) && !fifo_empty;
  assign out_hs        = m_axis_tvalid && m_axis_tready;

  assign push_data.id = s_axis_tdata_owner_programID;
  assign push_data.rd = s_axis_tdata_read_dependencies;
  assign push_data.wr = s_axis_tdata_write_dependencies;

  assign m_axis_tdata_owner_programID    = head.id;
  assign m_axis_tdata_read_dependencies  = head.rd;
  assign m_axis_tdata_write_dependencies = head.wr;
  assign queue_occupancy                 = 32'(fifo_count);

  sched_fifo #(
    .T     (txn_t),
    .DEPTH (INSERTION_QUEUE_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (push_data),
    .pop       (out_hs),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batch_rd_mask <= '0;
      batch_wr_mask <= '0;
      batch_count   <= '0;
      batch_timer   <= '0;
      release_count <= '0;
    end else begin
      if (close_now) begin
        batch_rd_mask <= '0;
        batch_wr_mask <= '0;
        batch_count   <= '0;
        batch_timer   <= '0;
      end else begin
        if (accept) begin
          batch_rd_mask <= batch_rd_mask | s_axis_tdata_read_dependencies;
          batch_wr_mask <= batch_wr_mask | s_axis_tdata_write_dependencies;
          batch_count   <= batch_count + 1'b1;
        end
        if (batch_count != '0) batch_timer <= batch_timer + 32'd1;
        else                   batch_timer <= '0;
      end
      release_count <= release_count + (close_now ? 32'(batch_count) : 32'd0) - {31'd0, out_hs};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_conflicts          <= '0;
      waw_conflicts          <= '0;
      war_conflicts          <= '0;
      filter_hits            <= '0;
      transactions_processed <= '0;
    end else begin
      raw_conflicts          <= raw_conflicts + {31'd0, in_hs && raw_hit};
      waw_conflicts          <= waw_conflicts + {31'd0, in_hs && waw_hit};
      war_conflicts          <= war_conflicts + {31'd0, in_hs && war_hit};
      filter_hits            <= filter_hits + {31'd0, in_hs && conflict};
      transactions_processed <= transactions_processed + {31'd0, out_hs};
    end
  end

endmodule

// File: tb/tb_svm_scheduler_top.sv
// Directed bench for svm_scheduler_top: conflict filtering, size/timeout close,
// backpressure, mask clearing after close and asynchronous reset.
module tb_svm_scheduler_top;
  import svm_sched_pkg::*;

  localparam int DW = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [63:0]   s_id;
  logic [DW-1:0] s_rd;
  logic [DW-1:0] s_wr;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [63:0]   m_id;
  logic [DW-1:0] m_rd;
  logic [DW-1:0] m_wr;
  logic [31:0]   raw_conflicts, waw_conflicts, war_conflicts;
  logic [31:0]   filter_hits, queue_occupancy, transactions_processed;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] out_q[$];

  always #5 clk = ~clk;

  svm_scheduler_top dut (
    .clk                             (clk),
    .rst_n                           (rst_n),
    .s_axis_tvalid                   (s_axis_tvalid),
    .s_axis_tready                   (s_axis_tready),
    .s_axis_tdata_owner_programID    (s_id),
    .s_axis_tdata_read_dependencies  (s_rd),
    .s_axis_tdata_write_dependencies (s_wr),
    .m_axis_tvalid                   (m_axis_tvalid),
    .m_axis_tready                   (m_axis_tready),
    .m_axis_tdata_owner_programID    (m_id),
    .m_axis_tdata_read_dependencies  (m_rd),
    .m_axis_tdata_write_dependencies (m_wr),
    .raw_conflicts                   (raw_conflicts),
    .waw_conflicts                   (waw_conflicts),
    .war_conflicts                   (war_conflicts),
    .filter_hits                     (filter_hits),
    .queue_occupancy                 (queue_occupancy),
    .transactions_processed          (transactions_processed)
  );

  always @(posedge clk)
    if (rst_n && m_axis_tvalid && m_axis_tready) out_q.push_back(m_id);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge with tvalid low.
  task automatic send(input int id, input int rb, input int wb);
    int n = 0;
    s_id = 64'(id);
    s_rd = '0;
    s_wr = '0;
    s_rd[rb] = 1'b1;
    s_wr[wb] = 1'b1;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("send_timeout", 64'(n), 64'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget, input string tag);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 64'(out_q.size()), 64'(n));
  endtask

  int t1_rd[10] = '{0, 2, 1, 5, 6, 1, 7, 8, 10, 11};
  int t1_wr[10] = '{1, 3, 4, 3, 2, 3, 8, 9, 9, 12};
  logic [63:0] t1_exp[5] = '{64'd1, 64'd2, 64'd7, 64'd9, 64'd10};

  initial begin
    s_axis_tvalid = 1'b0;
    s_id          = '0;
    s_rd          = '0;
    s_wr          = '0;
    m_axis_tready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_tready_low", 64'(s_axis_tready), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_tready_high", 64'(s_axis_tready), 64'd1);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_raw", 64'(raw_conflicts), 64'd0);
    chk("rst_filter", 64'(filter_hits), 64'd0);
    chk("rst_processed", 64'(transactions_processed), 64'd0);
    chk("rst_occupancy", 64'(queue_occupancy), 64'd0);
    @(negedge clk);

    // Conflict filtering, released on timeout
    for (int i = 0; i < 10; i++) begin
      send(i + 1, t1_rd[i], t1_wr[i]);
      repeat (5) @(negedge clk);
    end
    chk("t1_no_early_release", 64'(m_axis_tvalid), 64'd0);
    wait_outputs(5, 150, "t1_out_count");
    for (int i = 0; i < 5; i++) chk($sformatf("t1_id%0d", i), out_q[i], t1_exp[i]);
    chk("t1_raw", 64'(raw_conflicts), 64'd3);
    chk("t1_waw", 64'(waw_conflicts), 64'd2);
    chk("t1_war", 64'(war_conflicts), 64'd1);
    chk("t1_filter", 64'(filter_hits), 64'd5);
    chk("t1_processed", 64'(transactions_processed), 64'd5);
    chk("t1_occupancy", 64'(queue_occupancy), 64'd0);

    // Size close with back-to-back input
    out_q.delete();
    for (int i = 0; i < 8; i++) send(20 + i, 20 + i, 40 + i);
    chk("t2_close_tready", 64'(s_axis_tready), 64'd0);
    chk("t2_close_tvalid", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    chk("t2_release_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t2_release_head", m_id, 64'd20);
    // Reuses the closed batch's write bit 47: must be accepted
    send(100, 60, 47);
    wait_outputs(8, 30, "t2_out_count");
    for (int i = 0; i < 8; i++) chk($sformatf("t2_id%0d", i), out_q[i], 64'(20 + i));
    chk("t4_filter_unchanged", 64'(filter_hits), 64'd5);
    chk("t4_waw_unchanged", 64'(waw_conflicts), 64'd2);
    out_q.delete();
    wait_outputs(1, 150, "t4_out_count");
    chk("t4_id", out_q[0], 64'd100);
    chk("t4_processed", 64'(transactions_processed), 64'd14);

    // Downstream stall: FIFO fills, data holds, upstream blocked without drops
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h300 + i, 300 + i, 400 + i);
    @(negedge clk);
    chk("t3_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("t3_full_tready", 64'(s_axis_tready), 64'd0);
    chk("t3_occupancy", 64'(queue_occupancy), 64'd8);
    s_id = 64'h399;
    s_rd = '0;
    s_wr = '0;
    s_rd[500] = 1'b1;
    s_wr[501] = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t3_hold_tvalid%0d", i), 64'(m_axis_tvalid), 64'd1);
      chk($sformatf("t3_hold_id%0d", i), m_id, 64'h300);
      chk($sformatf("t3_hold_tready%0d", i), 64'(s_axis_tready), 64'd0);
    end
    chk("t3_wr_stable", m_wr[400 +: 8], 64'h01);
    chk("t3_no_drop", 64'(filter_hits), 64'd5);
    chk("t3_occupancy_hold", 64'(queue_occupancy), 64'd8);
    s_axis_tvalid = 1'b0;

    // Asynchronous reset while a batch is released and stalled
    rst_n = 1'b0;
    #1;
    chk("t5_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_tready", 64'(s_axis_tready), 64'd0);
    chk("t5_occupancy", 64'(queue_occupancy), 64'd0);
    chk("t5_raw", 64'(raw_conflicts), 64'd0);
    chk("t5_filter", 64'(filter_hits), 64'd0);
    chk("t5_processed", 64'(transactions_processed), 64'd0);
    chk("t5_head_id", m_id, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_tready_after", 64'(s_axis_tready), 64'd1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    out_q.delete();
    send(32'h500, 300, 400);
    wait_outputs(1, 150, "t5_out_count");
    chk("t5_post_id", out_q[0], 64'h500);
    chk("t5_post_processed", 64'(transactions_processed), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
